iq_sched: RTL and testbench
===========================

Name: iq_sched

Overview:
- Allocation and issue scheduler for one issue queue.
- Tracks which IQ entries are occupied and hands free entry indices to dispatch.
- Keeps the relative age of every entry in an age matrix.
- Each cycle selects the oldest entry that is both occupied and operand-ready, and offers it to the execution unit over a valid/ready handshake.
- Sits between dispatch/rename and the IQ payload RAM. Wakeup logic supplies the ready bits.

Parameters:
- IQ_DEPTH, 8, number of issue-queue entries (power of two, ≥2)
- SB_DEPTH, `SbDepth, scoreboard depth; sets the width of the carried tag
- IQ, $clog2(IQ_DEPTH), constant; entry index width
- SB, $clog2(SB_DEPTH), constant; scoreboard tag width
- AFULL_TH, IQ_DEPTH-2, occupancy at or above which almost_full asserts

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; invalidates all entries
- alloc_req  in  1  dispatch requests one entry
- alloc_sb_id  in  SB  scoreboard tag of the dispatching instruction
- alloc_ack  out  1  entry granted this cycle
- alloc_idx  out  IQ  granted entry index (valid when alloc_ack)
- ready_vec  in  IQ_DEPTH  per-entry operand-ready bits from wakeup
- issue_valid  out  1  an entry is offered for issue
- issue_idx  out  IQ  offered entry index
- issue_sb_id  out  SB  tag of the offered entry
- issue_ready  in  1  execution unit accepts the offered entry
- occupancy  out  IQ+1  count of valid entries
- full  out  1  occupancy == IQ_DEPTH
- empty  out  1  occupancy == 0
- almost_full  out  1  occupancy ≥ AFULL_TH

Behaviour:
- Reset:
  - valid[] = 0, age matrix = 0, sb_id[] = 0, occupancy = 0.
  - Outputs: full = 0, empty = 1, almost_full = 0, alloc_ack = 0, issue_valid = 0.
- State:
  - valid[IQ_DEPTH] and sb_id[IQ_DEPTH][SB].
  - age[i][j] = 1 means entry j is older than entry i.
  - occupancy register.
- Allocation (combinational from registered state):
  - alloc_ack = alloc_req & ~full & ~flush.
  - alloc_idx = lowest-index entry with valid == 0.
  - On ack, at the clock edge: valid[idx] ← 1, sb_id[idx] ← alloc_sb_id, age[idx][j] ← valid[j] for all j ≠ idx, age[j][idx] ← 0 for all j.
- Select (combinational):
  - cand[i] = valid[i] & ready_vec[i].
  - Winner is the i with cand[i] and no j where cand[j] & age[i][j].
  - issue_valid = |cand & ~flush; issue_idx/issue_sb_id come from the winner.
  - Exactly one winner whenever cand is non-zero (age is a strict total order over valid entries).
- Issue:
  - On issue_valid & issue_ready at the edge, valid[issue_idx] ← 0.
  - issue_valid/idx may change in any cycle without ready; this is not AXI-sticky.
- Latency:
  - An entry allocated in cycle N is first selectable in cycle N+1.
  - A newly allocated entry is never issued in its allocation cycle.
- Simultaneous alloc and issue:
  - Both take effect; occupancy is unchanged.
  - When full, alloc is not acked even if an issue frees an entry in the same cycle (no bypass).
  - The freed index may be reused from cycle N+1.
- Flush:
  - Highest priority; takes effect at the edge: valid[] ← 0, age ← 0, occupancy ← 0.
  - alloc_ack and issue_valid are forced to 0 during the flush cycle.
- Occupancy arithmetic:
  - occupancy += alloc_ack − (issue_valid & issue_ready).
  - full, empty and almost_full are decoded from the registered occupancy.
- Assertions: occupancy == popcount(valid); never alloc when full; a selected entry is always valid.
- Reset mid-operation: asynchronous clear to the reset values above; no drain.

Decomposition:
- Shared in issue.svh:
  - IqDepth, IqAddr widths.
  - typedef IqIdx_t, typedef IqVec_t.
  - struct IqIssue_t {idx, sb_id}.
- Sub-module iq_age_matrix:
  - Holds the age bits.
  - Inputs: set row/clear column on allocate, global clear on flush.
  - Outputs the oldest-candidate one-hot from cand.
- iq_sched owns valid[], sb_id[], occupancy, allocation priority encoder and output muxing.

Test Plan (IQ_DEPTH = 8, SB_DEPTH = 32):
- Alloc tags 5, 9, 3 in consecutive cycles, ready_vec = 0 → alloc_idx 0, 1, 2; occupancy 3; issue_valid = 0.
- Then ready_vec = 0b110, issue_ready = 1 → issues idx 1 (tag 9) then idx 2 (tag 3); idx 0 stays; occupancy 1.
- Fill 8 entries; in the next cycle assert alloc_req + issue handshake → alloc_ack = 0, occupancy 7, full deasserts. Alloc the following cycle → ack, reuses the freed index.
- Free idx 0, reallocate it with tag 20 after entries 1–7 were allocated; all ready → issue order is idx 1…7, then idx 0 (age, not index, decides).
- Flush with 5 valid entries while alloc_req = 1 and an issue is offered → alloc_ack = 0, issue_valid = 0; next cycle occupancy 0, empty = 1.
- Assert reset mid-stream with 4 valid entries → outputs immediately at reset values; after release, the first alloc gets idx 0.

Source files
------------

// File: rtl/iq_sched_pkg.sv
// Shared widths, types and helpers for the issue-queue scheduler.
// The typedefs describe the default configuration; modules derive their widths from their own parameters.
package iq_sched_pkg;

    localparam int IqDepth = 8;
    localparam int SbDepth = 32;
    localparam int IqAddr  = $clog2(IqDepth);
    localparam int SbAddr  = $clog2(SbDepth);

    typedef logic [IqAddr-1:0]  IqIdx_t;
    typedef logic [IqDepth-1:0] IqVec_t;
    typedef logic [SbAddr-1:0]  SbId_t;

    typedef struct packed {
        IqIdx_t idx;
        SbId_t  sb_id;
    } IqIssue_t;

    // almost_full threshold leaves room for two more dispatches in flight
    function automatic int afull_default(input int depth);
        return depth - 2;
    endfunction

endpackage

// File: rtl/iq_sched_if.sv
// Dispatch, wakeup, issue and status signals of the issue-queue scheduler.
// The scheduler attaches through the slave modport; the dispatch/issue side uses master.
interface iq_sched_if
    import iq_sched_pkg::*;
#(
    parameter int IQ_DEPTH = IqDepth,
    parameter int SB_DEPTH = SbDepth
);

    localparam int IQ = $clog2(IQ_DEPTH);
    localparam int SB = $clog2(SB_DEPTH);

    logic                flush;
    logic                alloc_req;
    logic [SB-1:0]       alloc_sb_id;
    logic                alloc_ack;
    logic [IQ-1:0]       alloc_idx;
    logic [IQ_DEPTH-1:0] ready_vec;
    logic                issue_valid;
    logic [IQ-1:0]       issue_idx;
    logic [SB-1:0]       issue_sb_id;
    logic                issue_ready;
    logic [IQ:0]         occupancy;
    logic                full;
    logic                empty;
    logic                almost_full;

    modport slave (
        input  flush, alloc_req, alloc_sb_id, ready_vec, issue_ready,
        output alloc_ack, alloc_idx, issue_valid, issue_idx, issue_sb_id,
               occupancy, full, empty, almost_full
    );

    modport master (
        output flush, alloc_req, alloc_sb_id, ready_vec, issue_ready,
        input  alloc_ack, alloc_idx, issue_valid, issue_idx, issue_sb_id,
               occupancy, full, empty, almost_full
    );

endinterface

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue: age[i][j] set means entry j is older than entry i.
// Produces a one-hot of the oldest candidate among the supplied candidate vector.
module iq_age_matrix #(
    parameter int IQ_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         alloc_en,
    input  logic [$clog2(IQ_DEPTH)-1:0]  alloc_idx,
    input  logic [IQ_DEPTH-1:0]          valid,
    input  logic [IQ_DEPTH-1:0]          cand,
    output logic [IQ_DEPTH-1:0]          oldest
);

    logic [IQ_DEPTH-1:0] age_q [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] alloc_oh;

    assign alloc_oh = IQ_DEPTH'(1) << alloc_idx;

    // New entry is younger than everything valid; nobody may consider it older than themselves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else if (alloc_en) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    age_q[i] <= valid & ~alloc_oh;
                end else begin
                    age_q[i] <= age_q[i] & ~alloc_oh;
                end
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            oldest[i] = cand[i] & ~(|(cand & age_q[i]));
        end
    end

endmodule

// File: rtl/iq_sched.sv
// Issue-queue allocation and oldest-ready select scheduler.
// Owns entry valid bits, carried scoreboard tags and occupancy; age ordering lives in iq_age_matrix.
module iq_sched
    import iq_sched_pkg::*;
#(
    parameter int IQ_DEPTH = IqDepth,
    parameter int SB_DEPTH = SbDepth,
    parameter int AFULL_TH = afull_default(IQ_DEPTH)
) (
    input logic       clk,
    input logic       reset,
    iq_sched_if.slave bus
);

    localparam int IQ    = $clog2(IQ_DEPTH);
    localparam int SB    = $clog2(SB_DEPTH);
    localparam int OCC_W = IQ + 1;

    logic [IQ_DEPTH-1:0] valid_q;
    logic [SB-1:0]       sb_q [IQ_DEPTH];
    logic [OCC_W-1:0]    occ_q;

    logic                full;
    logic                alloc_ack;
    logic [IQ-1:0]       free_idx;
    logic [IQ_DEPTH-1:0] cand;
    logic [IQ_DEPTH-1:0] oldest;
    logic [IQ-1:0]       win_idx;
    logic                issue_valid;
    logic                issue_fire;
    logic [IQ_DEPTH-1:0] alloc_mask;
    logic [IQ_DEPTH-1:0] issue_mask;

    // full comes from registered occupancy, so an entry freed this cycle is not bypassed to dispatch
    assign full      = (occ_q == OCC_W'(IQ_DEPTH));
    assign alloc_ack = bus.alloc_req & ~full & ~bus.flush;

    always_comb begin
        free_idx = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IQ'(i);
            end
        end
    end

    assign cand = valid_q & bus.ready_vec;

    iq_age_matrix #(
        .IQ_DEPTH (IQ_DEPTH)
    ) u_age (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.flush),
        .alloc_en  (alloc_ack),
        .alloc_idx (free_idx),
        .valid     (valid_q),
        .cand      (cand),
        .oldest    (oldest)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (oldest[i]) begin
                win_idx = IQ'(i);
            end
        end
    end

    assign issue_valid = (|cand) & ~bus.flush;
    assign issue_fire  = issue_valid & bus.issue_ready;
    assign alloc_mask  = alloc_ack  ? (IQ_DEPTH'(1) << free_idx) : '0;
    assign issue_mask  = issue_fire ? (IQ_DEPTH'(1) << win_idx)  : '0;

    // Alloc and issue never target the same entry: one is free, the other is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else if (bus.flush) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= (valid_q & ~issue_mask) | alloc_mask;
            occ_q   <= occ_q + OCC_W'(alloc_ack) - OCC_W'(issue_fire);
            if (alloc_ack) begin
                sb_q[free_idx] <= bus.alloc_sb_id;
            end
        end
    end

    assign bus.alloc_ack   = alloc_ack;
    assign bus.alloc_idx   = free_idx;
    assign bus.issue_valid = issue_valid;
    assign bus.issue_idx   = win_idx;
    assign bus.issue_sb_id = sb_q[win_idx];
    assign bus.occupancy   = occ_q;
    assign bus.full        = full;
    assign bus.empty       = (occ_q == '0);
    assign bus.almost_full = (occ_q >= OCC_W'(AFULL_TH));

    a_occ_popcount: assert property (@(posedge clk) disable iff (reset)
        occ_q == OCC_W'($countones(valid_q)));

    a_no_alloc_full: assert property (@(posedge clk) disable iff (reset)
        !(alloc_ack && full));

    a_issue_is_valid: assert property (@(posedge clk) disable iff (reset)
        !issue_valid || valid_q[win_idx]);

    a_single_winner: assert property (@(posedge clk) disable iff (reset)
        $onehot0(oldest));

endmodule

// File: tb/tb_iq_sched.sv
// Self-checking bench for iq_sched: allocations are pushed in age order to a scoreboard queue,
// and every issue handshake pops the oldest ready entry and compares it with the DUT.
module tb_iq_sched;
    import iq_sched_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    iq_sched_if #(.IQ_DEPTH(IqDepth), .SB_DEPTH(SbDepth)) bus ();

    iq_sched #(
        .IQ_DEPTH (IqDepth),
        .SB_DEPTH (SbDepth)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    IqIssue_t age_q[$];
    IqVec_t   m_valid;
    int       m_occ;

    task automatic check_output(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        age_q.delete();
        m_valid = '0;
        m_occ   = 0;
    endtask

    task automatic check_status();
        check_output("occupancy",   int'(bus.occupancy),   m_occ);
        check_output("full",        int'(bus.full),        int'(m_occ == IqDepth));
        check_output("empty",       int'(bus.empty),       int'(m_occ == 0));
        check_output("almost_full", int'(bus.almost_full), int'(m_occ >= IqDepth - 2));
    endtask

    // One clock cycle: drive inputs after the falling edge, check mid-low-phase, then advance the model.
    task automatic apply_stimulus(input logic req, input int tag, input IqVec_t rdy,
                                  input logic irdy, input logic fl);
        logic exp_ack;
        logic exp_iv;
        int   exp_aidx;
        int   pos;
        @(negedge clk);
        bus.alloc_req   = req;
        bus.alloc_sb_id = SbId_t'(tag);
        bus.ready_vec   = rdy;
        bus.issue_ready = irdy;
        bus.flush       = fl;
        #1;
        check_status();
        exp_ack  = req && (m_occ != IqDepth) && !fl;
        exp_aidx = -1;
        for (int i = IqDepth - 1; i >= 0; i--) begin
            if (!m_valid[i]) exp_aidx = i;
        end
        pos = -1;
        for (int k = 0; k < age_q.size(); k++) begin
            if (pos < 0 && rdy[age_q[k].idx]) pos = k;
        end
        exp_iv = (pos >= 0) && !fl;
        check_output("alloc_ack", int'(bus.alloc_ack), int'(exp_ack));
        if (exp_ack) check_output("alloc_idx", int'(bus.alloc_idx), exp_aidx);
        check_output("issue_valid", int'(bus.issue_valid), int'(exp_iv));
        if (exp_iv) begin
            check_output("issue_idx",   int'(bus.issue_idx),   int'(age_q[pos].idx));
            check_output("issue_sb_id", int'(bus.issue_sb_id), int'(age_q[pos].sb_id));
        end
        if (fl) begin
            model_reset();
        end else begin
            if (exp_iv && irdy) begin
                m_valid[age_q[pos].idx] = 1'b0;
                age_q.delete(pos);
                m_occ--;
            end
            if (exp_ack) begin
                age_q.push_back('{idx: IqIdx_t'(exp_aidx), sb_id: SbId_t'(tag)});
                m_valid[exp_aidx] = 1'b1;
                m_occ++;
            end
        end
    endtask

    initial begin
        bus.alloc_req   = 1'b0;
        bus.alloc_sb_id = '0;
        bus.ready_vec   = '0;
        bus.issue_ready = 1'b0;
        bus.flush       = 1'b0;
        model_reset();

        #3;
        check_status();
        check_output("reset_alloc_ack",   int'(bus.alloc_ack),   0);
        check_output("reset_issue_valid", int'(bus.issue_valid), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Three allocations with nothing ready, then selective issue of the younger two
        apply_stimulus(1'b1, 5, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 9, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b0, 0, 8'b110, 1'b1, 1'b0);
        apply_stimulus(1'b0, 0, 8'b110, 1'b1, 1'b0);
        apply_stimulus(1'b0, 0, 8'h00, 1'b0, 1'b0);

        // Fill, then alloc+issue while full (no bypass), then reuse the freed slot with tag 20
        for (int t = 10; t < 17; t++) apply_stimulus(1'b1, t, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 17, 8'hFF, 1'b1, 1'b0);
        apply_stimulus(1'b1, 20, 8'h00, 1'b0, 1'b0);

        // Drain with everything ready: age order is 1..7 then the reused idx 0
        for (int n = 0; n < 8; n++) apply_stimulus(1'b0, 0, 8'hFF, 1'b1, 1'b0);
        apply_stimulus(1'b0, 0, 8'h00, 1'b0, 1'b0);

        // Flush with five valid entries while alloc and issue are both offered
        for (int t = 21; t < 26; t++) apply_stimulus(1'b1, t, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 30, 8'hFF, 1'b1, 1'b1);
        apply_stimulus(1'b0, 0, 8'hFF, 1'b1, 1'b0);

        // Asynchronous reset in the middle of the low phase with four valid entries
        for (int t = 1; t < 5; t++) apply_stimulus(1'b1, t, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        bus.alloc_req   = 1'b0;
        bus.ready_vec   = 8'hFF;
        bus.issue_ready = 1'b0;
        bus.flush       = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_status();
        check_output("midreset_alloc_ack",   int'(bus.alloc_ack),   0);
        check_output("midreset_issue_valid", int'(bus.issue_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(1'b1, 7, 8'h00, 1'b0, 1'b0);

        // Random traffic against the scoreboard model
        for (int n = 0; n < 80; n++) begin
            apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                           IqVec_t'($urandom), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 24) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
